// File: rtl/core_pkg.sv
// Shared core constants: writeback requester ids,
// default requester count and counter limits.
package core_pkg;

  localparam int NUM_REQ_DEF = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MUL = 2;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: first set request at or
// after ptr, wrapping, wins a one-hot grant.
module rr_arbiter
  import core_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic found;
  int   idx;

  // scan from ptr upward, modulo NUM_REQ
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks one requester per cycle
// and registers it onto the register-file write port.
module regfile_wb_arbiter
  import core_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int XLEN    = 32,
  parameter int AW      = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    flush,
  output logic                    rf_write_enable,
  output logic [AW-1:0]           rf_write_addr,
  output logic [XLEN-1:0]         rf_write_data,
  output logic [15:0]             conflict_count
);

  localparam int IW = idx_w(NUM_REQ);

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      grant_idx;
  logic [IW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] req_live;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic               multi_req;
  logic [AW-1:0]      sel_addr;
  logic [XLEN-1:0]    sel_data;
  int                 n_valid;

  assign req_live = (reset_n && !flush) ? req_valid
                                        : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req       (req_live),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign sel_addr  = req_addr[grant_idx*AW +: AW];
  assign sel_data  = req_data[grant_idx*XLEN +: XLEN];
  assign next_ptr  =
    (int'(grant_idx) == NUM_REQ - 1) ? '0
                                     : grant_idx + 1'b1;

  // count simultaneous requesters
  always_comb begin
    n_valid = 0;
    for (int i = 0; i < NUM_REQ; i++)
      n_valid = n_valid + int'(req_valid[i]);
    multi_req = (n_valid > 1);
  end

  // pointer, output stage and conflict counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr          <= '0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
      conflict_count  <= '0;
    end else begin
      if (flush)
        rr_ptr <= '0;
      else if (any_grant)
        rr_ptr <= next_ptr;
      rf_write_enable <= any_grant &&
                         (sel_addr != '0);
      if (any_grant) begin
        rf_write_addr <= sel_addr;
        rf_write_data <= sel_data;
      end
      if (!flush && multi_req &&
          conflict_count != CNT_MAX)
        conflict_count <= conflict_count + 16'd1;
    end
  end

endmodule
